data_mem_responder: RTL and testbench

- Memory-side responder for the data-cache miss/write-through interface. Serves cache refill reads and write-through writes from the data cache.
- Replaces the zero-latency combinational data memory with a word-organised array that has a fixed, parameterised access latency.
- Signals completion with a one-cycle `mem_ready` pulse plus an error flag. This lets the cache's miss state machine be exercised against real memory latency.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_lane_unit.sv | 40 ++++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: access modes, FSM encoding
// and the default access latency.
package dmem_pkg;

    localparam logic [2:0] MODE_BYTE = 3'd1;
    localparam logic [2:0] MODE_WORD = 3'd2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int DEFAULT_LATENCY = 3;

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering for the data memory: extracts the zero-extended read
// value, builds the merged write word and flags misaligned or illegal modes.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_sel,
    input  logic [2:0]  mode,
    input  logic [31:0] wdata,
    output logic [31:0] rd_val,
    output logic [31:0] wr_word,
    output logic        mode_err
);

    logic [4:0] lane_shift_s;

    assign lane_shift_s = {byte_sel, 3'b000};

    // Little-endian lane select for byte mode, full word otherwise.
    always_comb begin
        rd_val   = 32'h0000_0000;
        wr_word  = word;
        mode_err = 1'b0;
        case (mode)
            MODE_WORD: begin
                rd_val   = word;
                wr_word  = wdata;
                mode_err = (byte_sel != 2'b00);
            end
            MODE_BYTE: begin
                rd_val                     = {24'h00_0000, word[lane_shift_s +: 8]};
                wr_word[lane_shift_s +: 8] = wdata[7:0];
            end
            default: begin
                mode_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a fixed access latency, answering cache
// refill reads and write-through writes with a one-cycle ready pulse.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = DEFAULT_LATENCY,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_mode,
    input  logic        mem_write_en,
    input  logic        mem_read_en,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_r [DEPTH_WORDS];
    logic [1:0]       state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [31:0]      addr_r, wdata_r;
    logic [2:0]       mode_r;
    logic             wr_r, rd_r;
    logic [31:0]      mem_rdata_r;
    logic             mem_ready_r, mem_err_r, busy_r;

    logic             accept_s, fire_s, range_err_s, mode_err_s, err_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rd_val_s, wr_word_s;

    assign accept_s    = (state_r == S_IDLE) && (mem_read_en || mem_write_en);
    assign fire_s      = (state_r == S_BUSY) && (cnt_r == {CNT_W{1'b0}});
    assign idx_s       = addr_r[IDX_W+1:2];
    assign range_err_s = ({2'b00, addr_r[31:2]} >= 32'(DEPTH_WORDS));
    assign err_s       = range_err_s || mode_err_s || (wr_r && rd_r);

    dmem_lane_unit u_lane (
        .word     (mem_r[idx_s]),
        .byte_sel (addr_r[1:0]),
        .mode     (mode_r),
        .wdata    (wdata_r),
        .rd_val   (rd_val_s),
        .wr_word  (wr_word_s),
        .mode_err (mode_err_s)
    );

    // Every request passes through BUSY so that ready lands LATENCY edges
    // after the accept edge, including LATENCY = 1.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nx_s = S_BUSY;
                    cnt_nx_s   = CNT_W'(LATENCY - 1);
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nx_s = S_DONE;
                end else begin
                    cnt_nx_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_nx_s = S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control state, request capture and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            mode_r      <= 3'd0;
            wr_r        <= 1'b0;
            rd_r        <= 1'b0;
            mem_rdata_r <= 32'h0000_0000;
            mem_ready_r <= 1'b0;
            mem_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            busy_r      <= (state_nx_s != S_IDLE);
            mem_ready_r <= fire_s;
            mem_err_r   <= fire_s && err_s;
            if (fire_s && rd_r) begin
                mem_rdata_r <= err_s ? 32'h0000_0000 : rd_val_s;
            end
            if (accept_s) begin
                addr_r  <= mem_addr;
                wdata_r <= mem_wdata;
                mode_r  <= mem_mode;
                wr_r    <= mem_write_en;
                rd_r    <= mem_read_en;
            end
        end
    end

    // Storage array: never reset, written only by a clean write completion.
    always_ff @(posedge clk) begin
        if (fire_s && wr_r && !err_s) begin
            mem_r[idx_s] <= wr_word_s;
        end
    end

    assign mem_rdata = mem_rdata_r;
    assign mem_ready = mem_ready_r;
    assign mem_err   = mem_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder against a flat word-array model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_mode;
    logic        mem_write_en, mem_read_en, mem_ready, mem_err, busy;

    logic [31:0] mdl [DEPTH];
    logic [31:0] last_rd;
    int          n_total = 0;
    int          n_bad   = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_mode     (mem_mode),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_err      (mem_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected read value from the model, straight from the addressing rules.
    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [2:0] mode);
        logic [31:0] w;
        w = mdl[(addr / 4) % DEPTH];
        if (mode == 3'd2) return w;
        return (w >> (8 * (addr % 4))) & 32'h0000_00FF;
    endfunction

    function automatic logic model_err(input bit wr, input bit rd, input logic [31:0] addr,
                                       input logic [2:0] mode);
        return (wr && rd) || !(mode == 3'd1 || mode == 3'd2) ||
               (mode == 3'd2 && (addr % 4) != 0) || ((addr / 4) >= DEPTH);
    endfunction

    // Waits (bounded) for mem_ready; returns edges counted from the call.
    task automatic wait_ready(output int edges);
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (mem_ready) break;
        end
    endtask

    // Issues one request from IDLE and checks latency, error and data.
    task automatic do_req(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] mode, input bit swap_addr);
        logic        e_err;
        logic [31:0] w;
        int          edges;
        e_err = model_err(wr, rd, addr, mode);
        mem_write_en = wr;
        mem_read_en  = rd;
        mem_addr     = addr;
        mem_wdata    = wdata;
        mem_mode     = mode;
        @(posedge clk);
        #1;
        check_val("busy_after_accept", {31'd0, busy}, 32'd1);
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        if (swap_addr) mem_addr = addr ^ 32'h0000_00C0;
        mem_wdata = ~wdata;
        mem_mode  = 3'd5;
        wait_ready(edges);
        check_val("ready_latency", edges, LAT);
        check_val("err", {31'd0, mem_err}, {31'd0, e_err});
        if (rd) last_rd = e_err ? 32'h0 : model_read(addr, mode);
        check_val("rdata", mem_rdata, last_rd);
        if (wr && !e_err) begin
            w = mdl[addr / 4];
            if (mode == 3'd2) w = wdata;
            else begin
                w = w & ~(32'h0000_00FF << (8 * (addr % 4)));
                w = w | ((wdata & 32'h0000_00FF) << (8 * (addr % 4)));
            end
            mdl[addr / 4] = w;
        end
        @(posedge clk);
        #1;
        check_val("ready_one_cycle", {31'd0, mem_ready}, 32'd0);
        check_val("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int          edges;
        int          pulses;
        logic [31:0] a, d;
        logic [2:0]  m;
        int          sel;

        reset = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_mode = 3'd2;
        mem_write_en = 1'b0; mem_read_en = 1'b0;
        last_rd = 32'h0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rdata", mem_rdata, 32'h0);
        check_val("rst_ready", {31'd0, mem_ready}, 32'd0);
        check_val("rst_err", {31'd0, mem_err}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Give the low 256 bytes defined contents.
        for (int i = 0; i < 64; i++) do_req(1'b1, 1'b0, 32'(i * 4), $urandom, 3'd2, 1'b0);

        do_req(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 3'd2, 1'b0);
        do_req(1'b0, 1'b1, 32'h40, 32'h0, 3'd2, 1'b0);
        check_val("word_rd_40", mem_rdata, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h41, 32'hFFFF_FF11, 3'd1, 1'b0);
        do_req(1'b0, 1'b1, 32'h40, 32'h0, 3'd2, 1'b0);
        check_val("byte_merge_40", mem_rdata, 32'hDEAD_11EF);
        do_req(1'b0, 1'b1, 32'h43, 32'h0, 3'd1, 1'b0);
        check_val("byte_rd_43", mem_rdata, 32'h0000_00DE);

        do_req(1'b0, 1'b1, 32'h42, 32'h0, 3'd2, 1'b0);
        do_req(1'b0, 1'b1, 32'h40, 32'h0, 3'd3, 1'b0);
        do_req(1'b0, 1'b1, 32'h1000, 32'h0, 3'd2, 1'b0);
        do_req(1'b1, 1'b1, 32'h40, 32'h5555_5555, 3'd2, 1'b0);
        do_req(1'b0, 1'b1, 32'h40, 32'h0, 3'd2, 1'b0);
        check_val("both_no_write", mem_rdata, 32'hDEAD_11EF);

        // Reset in BUSY discards the pending write.
        mem_write_en = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h1234_5678; mem_mode = 3'd2;
        @(posedge clk);
        #1;
        mem_write_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_val("midrst_rdata", mem_rdata, 32'h0);
        check_val("midrst_ready", {31'd0, mem_ready}, 32'd0);
        check_val("midrst_err", {31'd0, mem_err}, 32'd0);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        last_rd = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) pulses++;
        end
        check_val("midrst_no_ready", pulses, 0);
        do_req(1'b0, 1'b1, 32'h80, 32'h0, 3'd2, 1'b0);

        // Address changes during BUSY are ignored.
        do_req(1'b0, 1'b1, 32'h40, 32'h0, 3'd2, 1'b1);
        check_val("addr_swap_40", mem_rdata, 32'hDEAD_11EF);

        // Enable held through DONE: new accept in the following IDLE cycle.
        mem_read_en = 1'b1; mem_addr = 32'h40; mem_mode = 3'd2;
        @(posedge clk);
        #1;
        wait_ready(edges);
        check_val("held_first_lat", edges, LAT);
        check_val("held_first_data", mem_rdata, 32'hDEAD_11EF);
        wait_ready(edges);
        check_val("held_second_lat", edges, LAT + 2);
        check_val("held_second_data", mem_rdata, 32'hDEAD_11EF);
        mem_read_en = 1'b0;
        last_rd = 32'hDEAD_11EF;
        @(posedge clk);
        #1;
        check_val("held_idle", {31'd0, busy}, 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h1000 + ($urandom & 32'h0000_0FFF);
            else if (sel == 1) a = $urandom;
            else               a = $urandom_range(0, 255);
            sel = $urandom_range(0, 9);
            if (sel == 0)      m = 3'($urandom_range(0, 7));
            else if (sel < 5)  m = 3'd1;
            else               m = 3'd2;
            if (m == 3'd2 && $urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
            d   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)     do_req(1'b1, 1'b1, a, d, m, 1'b0);
            else if (sel < 5) do_req(1'b1, 1'b0, a, d, m, 1'b0);
            else              do_req(1'b0, 1'b1, a, d, m, sel[0]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
